// File: rtl/aes_decrypt.sv
// aes_decrypt: iterative AES-128 inverse cipher, one round per clock.
// The key is expanded forward to rk10, then rolled back one round key per decryption round.
module aes_decrypt #(
    parameter int NK = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key,
    input  logic         load,
    input  logic [127:0] ct,
    output logic [127:0] pt,
    output logic         valid,
    output logic         busy
);
    if (NK != 4) begin : g_nk_check
        $error("aes_decrypt supports only NK=4 (AES-128)");
    end

    typedef enum logic [1:0] {IDLE, KEXP, DEC} state_t;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    localparam logic [2047:0] ISBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

    function automatic logic [7:0] sb(input logic [7:0] x);
        return SBOX[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] isb(input logic [7:0] x);
        return ISBOX[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [3:0] c);
        logic [7:0] a2, a4, a8;
        a2 = xt(a);
        a4 = xt(a2);
        a8 = xt(a4);
        return (c[0] ? a : 8'h00) ^ (c[1] ? a2 : 8'h00) ^ (c[2] ? a4 : 8'h00) ^ (c[3] ? a8 : 8'h00);
    endfunction

    // rcon for rounds 1..10 is successive doubling of 01 in GF(2^8)
    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] rc;
        rc = 8'h01;
        for (int i = 2; i <= 10; i++) if (4'(i) <= r) rc = xt(rc);
        return rc;
    endfunction

    function automatic logic [7:0] bt(input logic [127:0] s, input int i);
        return s[127-8*i -: 8];
    endfunction

    function automatic logic [127:0] inv_sr_sb(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = isb(bt(s, 4*((c+4-r)%4)+r));
        return o;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = gm(bt(s, 4*c+r), 4'he) ^ gm(bt(s, 4*c+(r+1)%4), 4'hb)
                                      ^ gm(bt(s, 4*c+(r+2)%4), 4'hd) ^ gm(bt(s, 4*c+(r+3)%4), 4'h9);
        return o;
    endfunction

    function automatic logic [31:0] sub_rot(input logic [31:0] w);
        return {sb(w[23:16]), sb(w[15:8]), sb(w[7:0]), sb(w[31:24])};
    endfunction

    function automatic logic [127:0] fwd_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w0 = k[127:96] ^ sub_rot(k[31:0]) ^ {rc, 24'h0};
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] inv_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w3 = k[31:0] ^ k[63:32];
        w2 = k[63:32] ^ k[95:64];
        w1 = k[95:64] ^ k[127:96];
        w0 = k[127:96] ^ sub_rot(w3) ^ {rc, 24'h0};
        return {w0, w1, w2, w3};
    endfunction

    state_t       state_q;
    logic         load_q, valid_q, busy_q;
    logic [3:0]   round_q;
    logic [127:0] ct_q, rk_q, blk_q, pt_q;
    logic [127:0] rk_f_d, rk_b_d, sr_sb_d;
    logic         start;

    assign start   = load & ~load_q & ~busy_q;
    assign rk_f_d  = fwd_key(rk_q, rcon(round_q));
    assign rk_b_d  = inv_key(rk_q, rcon(round_q + 4'd1));
    assign sr_sb_d = inv_sr_sb(blk_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            load_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            round_q <= 4'd0;
            ct_q    <= '0;
            rk_q    <= '0;
            blk_q   <= '0;
            pt_q    <= '0;
        end else begin
            load_q <= load;
            case (state_q)
                IDLE: if (start) begin
                    ct_q    <= ct;
                    rk_q    <= key;
                    round_q <= 4'd1;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b1;
                    state_q <= KEXP;
                end
                KEXP: begin
                    rk_q <= rk_f_d;
                    if (round_q == 4'd10) begin
                        blk_q   <= ct_q ^ rk_f_d;
                        round_q <= 4'd9;
                        state_q <= DEC;
                    end else round_q <= round_q + 4'd1;
                end
                DEC: begin
                    rk_q <= rk_b_d;
                    if (round_q == 4'd0) begin
                        pt_q    <= sr_sb_d ^ rk_b_d;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        blk_q   <= inv_mix(sr_sb_d ^ rk_b_d);
                        round_q <= round_q - 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pt    = pt_q;
    assign valid = valid_q;
    assign busy  = busy_q;
endmodule

// File: tb/tb_aes_decrypt.sv
// tb_aes_decrypt: FIPS-197 vectors, encrypt->decrypt loopback and handshake corner cases
// checked against a cycle-level reference built on a full-expansion AES model.
module tb_aes_decrypt;
    logic         clk = 1'b0, rst = 1'b1, load = 1'b0;
    logic [127:0] key = '0, ct = '0, pt;
    logic         valid, busy;
    int           errors = 0, checks = 0, printed = 0, rises = 0;
    logic         v_prev = 1'b0;
    logic [7:0]   sbox [256];
    logic [7:0]   isbox [256];

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K3 = 128'hfefd00d583ef87e9b7e6ab3a655f68db;
    localparam logic [127:0] P3 = 128'h05060708090a0b0c0d0e0f1011121314;

    always #5 clk = ~clk;

    aes_decrypt dut (.clk(clk), .rst(rst), .key(key), .load(load), .ct(ct), .pt(pt), .valid(valid), .busy(busy));

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (printed < 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
            printed++;
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    function automatic logic [127:0] round_key(input logic [127:0] k, input int rd);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*rd], w[4*rd+1], w[4*rd+2], w[4*rd+3]};
    endfunction

    function automatic logic [7:0] gb(input logic [127:0] s, input int r, input int c);
        return s[127-8*(r+4*c) -: 8];
    endfunction

    function automatic logic [127:0] mix(input logic [127:0] s, input logic [7:0] m0, m1, m2, m3);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = gmul(m0, gb(s, r, c)) ^ gmul(m1, gb(s, (r+1)%4, c))
                                      ^ gmul(m2, gb(s, (r+2)%4, c)) ^ gmul(m3, gb(s, (r+3)%4, c));
        return o;
    endfunction

    function automatic logic [127:0] model_enc(input logic [127:0] k, input logic [127:0] p);
        logic [127:0] s, t;
        s = p ^ round_key(k, 0);
        for (int rd = 1; rd <= 10; rd++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[127-8*(r+4*c) -: 8] = sbox[gb(s, r, (c+r)%4)];
            if (rd < 10) t = mix(t, 8'h02, 8'h03, 8'h01, 8'h01);
            s = t ^ round_key(k, rd);
        end
        return s;
    endfunction

    function automatic logic [127:0] model_dec(input logic [127:0] k, input logic [127:0] c_in);
        logic [127:0] s, t;
        s = c_in ^ round_key(k, 10);
        for (int rd = 9; rd >= 0; rd--) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[127-8*(r+4*c) -: 8] = isbox[gb(s, r, (c+4-r)%4)];
            t ^= round_key(k, rd);
            s = (rd > 0) ? mix(t, 8'h0e, 8'h0b, 8'h0d, 8'h09) : t;
        end
        return s;
    endfunction

    // Cycle-level reference: a start captures key/ct, the plaintext appears 20 edges later.
    logic [127:0] m_pt = '0, m_key = '0, m_ct = '0;
    logic         m_valid = 1'b0, m_busy = 1'b0, m_ld = 1'b0;
    int           m_cnt = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pt <= '0; m_valid <= 1'b0; m_busy <= 1'b0; m_ld <= 1'b0; m_cnt <= 0;
        end else begin
            if (m_busy) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_pt <= model_dec(m_key, m_ct); m_valid <= 1'b1; m_busy <= 1'b0;
                end
            end else if (load && !m_ld) begin
                m_key <= key; m_ct <= ct; m_cnt <= 20; m_busy <= 1'b1; m_valid <= 1'b0;
            end
            m_ld <= load;
        end
    end

    always @(negedge clk) begin
        chk("cyc_pt", pt, m_pt);
        chk("cyc_valid", {127'b0, valid}, {127'b0, m_valid});
        chk("cyc_busy", {127'b0, busy}, {127'b0, m_busy});
        if (valid && !v_prev) rises++;
        v_prev <= valid;
    end

    // Issues one start; optionally raises load again at cycle `poke` with a different ct.
    task automatic run(input logic [127:0] k, input logic [127:0] c, input int poke,
                       output logic [127:0] p, output int lat);
        @(negedge clk);
        key = k; ct = c; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        lat = 0;
        while (!valid && lat < 60) begin
            @(negedge clk);
            lat++;
            if (lat == poke) begin load = 1'b1; ct = ~c; end
            else load = 1'b0;
        end
        load = 1'b0;
        p = pt;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        logic [127:0] p, c, k, ref_p;
        logic [7:0]   inv;
        int           lat, r0;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) isbox[sbox[x]] = 8'(x);
        chk("model_sbox00", {120'b0, sbox[0]}, 128'h63);
        chk("model_isbox00", {120'b0, isbox[0]}, 128'h52);
        chk("model_dec_c1", model_dec(K1, C1), P1);
        chk("model_enc_c1", model_enc(K1, P1), C1);
        chk("model_enc_b", model_enc(K2, P2), C2);
        repeat (3) @(negedge clk);
        chk("reset_pt", pt, 128'h0);
        chk("reset_flags", {126'b0, valid, busy}, 128'h0);
        rst = 1'b0;

        run(K1, C1, 0, p, lat);
        chk("c1_pt", p, P1);
        chk("c1_latency", 128'(lat), 128'd20);
        run(K2, C2, 0, p, lat);
        chk("appb_pt", p, P2);

        c = model_enc(K3, P3);
        run(K3, c, 0, p, lat);
        chk("loop_pt", p, P3);
        for (int i = 0; i < 200; i++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            ref_p = {$urandom, $urandom, $urandom, $urandom};
            run(k, model_enc(k, ref_p), 0, p, lat);
            chk("loop_rand_pt", p, ref_p);
        end

        run(K1, C1, 5, p, lat);
        chk("drop_pt", p, P1);
        chk("drop_latency", 128'(lat), 128'd20);
        chk("drop_busy", {127'b0, busy}, 128'h0);
        repeat (25) @(negedge clk);
        chk("drop_no_restart", {126'b0, valid, busy}, 128'h2);

        r0 = rises;
        key = K2; ct = C2; load = 1'b1;
        repeat (100) @(negedge clk);
        chk("level_one_rise", 128'(rises - r0), 128'd1);
        load = 1'b0;
        @(negedge clk);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (25) @(negedge clk);
        chk("level_second_rise", 128'(rises - r0), 128'd2);
        chk("level_second_pt", pt, P2);

        key = K1; ct = C1; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (11) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_pt", pt, 128'h0);
        chk("rst_mid_flags", {126'b0, valid, busy}, 128'h0);
        @(negedge clk);
        rst = 1'b0;
        run(K2, C2, 0, p, lat);
        chk("rst_after_pt", p, P2);
        chk("rst_after_latency", 128'(lat), 128'd20);

        @(negedge clk);
        rst = 1'b1; load = 1'b1; key = K1; ct = C1;
        @(negedge clk);
        rst = 1'b0; load = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_vs_load_busy", {127'b0, busy}, 128'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
